e_mdu: RTL and testbench

Execute-stage multiply/divide unit owning the HI/LO registers. It accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from the E-stage datapath and runs multi-cycle operations with a countdown. It drives `busy` into the stall unit's `hl_busy` input, so D-stage HI/LO-class instructions stall while an operation is in flight. The E-stage `req` flush suppresses architectural side effects of a flushed instruction.

---
 rtl/e_mdu_if.sv | 21 ++
 rtl/e_mdu.sv | 146 ++++++++++++++
 tb/tb_e_mdu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// E-stage datapath <-> multiply/divide unit bus.
// The master side issues operations and operands; the slave side is the MDU.
interface e_mdu_if;
   logic [3:0]  mdu_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        req;
   logic        start;
   logic        busy;
   logic [31:0] hl_out;

   modport master (
      output mdu_op, A, B, req,
      input  start, busy, hl_out
   );

   modport slave (
      input  mdu_op, A, B, req,
      output start, busy, hl_out
   );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO.
// Multi-cycle ops latch their result at start and commit it when the countdown expires.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic    clk,
   input logic    reset,
   e_mdu_if.slave mdu
);
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } op_e;

   logic [31:0]      hi_r;
   logic [31:0]      lo_r;
   logic [31:0]      pend_hi_r;
   logic [31:0]      pend_lo_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             busy_r;
   logic             div0_r;

   logic             is_mul_s;
   logic             is_div_s;
   logic             sgn_s;
   logic             start_s;
   logic             wr_hi_s;
   logic             wr_lo_s;
   logic [63:0]      mul_a_s;
   logic [63:0]      mul_b_s;
   logic [63:0]      prod_s;
   logic [31:0]      a_mag_s;
   logic [31:0]      b_mag_s;
   logic [31:0]      dvs_s;
   logic [31:0]      q_mag_s;
   logic [31:0]      r_mag_s;
   logic [31:0]      quo_s;
   logic [31:0]      rem_s;
   logic [31:0]      res_hi_s;
   logic [31:0]      res_lo_s;
   logic [31:0]      hl_out_s;

   // Opcode decode and accept/write qualification
   always_comb begin
      is_mul_s = 1'b0;
      is_div_s = 1'b0;
      sgn_s    = 1'b0;
      case (mdu.mdu_op)
         OP_MULT:  begin is_mul_s = 1'b1; sgn_s = 1'b1; end
         OP_MULTU: is_mul_s = 1'b1;
         OP_DIV:   begin is_div_s = 1'b1; sgn_s = 1'b1; end
         OP_DIVU:  is_div_s = 1'b1;
         default:  is_mul_s = 1'b0;
      endcase
      start_s = (is_mul_s | is_div_s) & ~mdu.req & ~busy_r;
      wr_hi_s = (mdu.mdu_op == OP_MTHI) & ~mdu.req & ~busy_r;
      wr_lo_s = (mdu.mdu_op == OP_MTLO) & ~mdu.req & ~busy_r;
   end

   // Result datapath; signed divide works on magnitudes, so 0x80000000 / -1
   // falls out naturally as LO = 0x80000000, HI = 0.
   always_comb begin
      mul_a_s = sgn_s ? {{32{mdu.A[31]}}, mdu.A} : {32'd0, mdu.A};
      mul_b_s = sgn_s ? {{32{mdu.B[31]}}, mdu.B} : {32'd0, mdu.B};
      prod_s  = mul_a_s * mul_b_s;
      a_mag_s = (sgn_s & mdu.A[31]) ? (32'd0 - mdu.A) : mdu.A;
      b_mag_s = (sgn_s & mdu.B[31]) ? (32'd0 - mdu.B) : mdu.B;
      dvs_s   = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
      q_mag_s = a_mag_s / dvs_s;
      r_mag_s = a_mag_s % dvs_s;
      quo_s   = (sgn_s & (mdu.A[31] ^ mdu.B[31])) ? (32'd0 - q_mag_s) : q_mag_s;
      rem_s   = (sgn_s & mdu.A[31]) ? (32'd0 - r_mag_s) : r_mag_s;
      if (is_div_s) begin
         res_hi_s = rem_s;
         res_lo_s = quo_s;
      end else begin
         res_hi_s = prod_s[63:32];
         res_lo_s = prod_s[31:0];
      end
   end

   // Countdown next value
   always_comb begin
      if (start_s) begin
         cnt_nxt_s = is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt_r != {CNT_W{1'b0}}) begin
         cnt_nxt_s = cnt_r - CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // HI/LO read mux
   always_comb begin
      case (mdu.mdu_op)
         OP_MFHI: hl_out_s = hi_r;
         OP_MFLO: hl_out_s = lo_r;
         default: hl_out_s = 32'd0;
      endcase
   end

   // Architectural and pending state
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
         pend_hi_r <= 32'd0;
         pend_lo_r <= 32'd0;
         cnt_r     <= {CNT_W{1'b0}};
         busy_r    <= 1'b0;
         div0_r    <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         busy_r <= (cnt_nxt_s != {CNT_W{1'b0}});
         if (start_s) begin
            pend_hi_r <= res_hi_s;
            pend_lo_r <= res_lo_s;
            div0_r    <= is_div_s & (mdu.B == 32'd0);
         end
         // Commit edge and mthi/mtlo are mutually exclusive: writes need !busy.
         if ((cnt_r == CNT_W'(1)) && !div0_r) begin
            hi_r <= pend_hi_r;
            lo_r <= pend_lo_r;
         end else begin
            if (wr_hi_s) hi_r <= mdu.A;
            if (wr_lo_s) lo_r <= mdu.A;
         end
      end
   end

   assign mdu.start  = start_s;
   assign mdu.busy   = busy_r;
   assign mdu.hl_out = hl_out_s;
endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu with hand-computed HI/LO results.
module tb_e_mdu;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   e_mdu_if bus ();

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rq);
      bus.mdu_op = op;
      bus.A      = a;
      bus.B      = b;
      bus.req    = rq;
      #1;
   endtask

   task automatic check_hl(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      drive(4'd5, 32'd0, 32'd0, 1'b0);
      check_eq({tag, "_hi"}, bus.hl_out, exp_hi);
      drive(4'd6, 32'd0, 32'd0, 1'b0);
      check_eq({tag, "_lo"}, bus.hl_out, exp_lo);
      drive(4'd0, 32'd0, 32'd0, 1'b0);
   endtask

   // Issue an op expected to be accepted, then count busy cycles (bounded).
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc);
      int n;
      drive(op, a, b, 1'b0);
      check_eq({tag, "_start"}, {31'd0, bus.start}, 32'd1);
      tick();
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      check_eq({tag, "_start_once"}, {31'd0, bus.start}, 32'd0);
      n = 0;
      while (bus.busy && n < 20) begin
         tick();
         n++;
      end
      check_eq({tag, "_busy_cycles"}, n, exp_cyc);
   endtask

   initial begin
      int n;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
      check_hl("reset", 32'd0, 32'd0);

      run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5);
      check_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      tick();

      run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
      check_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);
      tick();

      run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
      check_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      tick();

      run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      check_hl("div_ovf", 32'h0000_0000, 32'h8000_0000);
      tick();

      drive(4'd7, 32'h1234_5678, 32'd0, 1'b0);
      tick();
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      check_hl("mthi", 32'h1234_5678, 32'h8000_0000);
      tick();

      run_op("divu_zero", 4'd4, 32'd5, 32'd0, 10);
      check_hl("divu_zero", 32'h1234_5678, 32'h8000_0000);
      tick();

      // Operations under flush must leave no trace
      drive(4'd1, 32'd3, 32'd4, 1'b1);
      check_eq("req_mult_start", {31'd0, bus.start}, 32'd0);
      tick();
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      check_eq("req_mult_busy", {31'd0, bus.busy}, 32'd0);
      check_hl("req_mult", 32'h1234_5678, 32'h8000_0000);
      drive(4'd8, 32'h0000_00AA, 32'd0, 1'b1);
      tick();
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      check_hl("req_mtlo", 32'h1234_5678, 32'h8000_0000);
      tick();

      // divu 100/7 with flush and a dropped mult while in flight
      drive(4'd4, 32'd100, 32'd7, 1'b0);
      check_eq("divu_start", {31'd0, bus.start}, 32'd1);
      tick();
      n = 0;
      while (bus.busy && n < 20) begin
         if (n == 1) begin
            drive(4'd1, 32'd9, 32'd9, 1'b1);
            check_eq("busy_req_start", {31'd0, bus.start}, 32'd0);
         end else if (n == 2) begin
            drive(4'd1, 32'd9, 32'd9, 1'b0);
            check_eq("busy_mult_start", {31'd0, bus.start}, 32'd0);
         end else begin
            drive(4'd0, 32'd0, 32'd0, 1'b0);
         end
         tick();
         n++;
      end
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      check_eq("divu_busy_cycles", n, 32'd10);
      check_hl("divu", 32'd2, 32'd14);
      tick();

      // Reset in busy cycle 3 aborts the op and clears HI/LO
      run_op("pre_rst", 4'd1, 32'd0, 32'd0, 5);
      drive(4'd1, 32'd5, 32'd5, 1'b0);
      tick();
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      check_eq("rst_mid_busy_pre", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      check_hl("rst_mid", 32'd0, 32'd0);
      for (int i = 0; i < 6; i++) tick();
      check_eq("rst_mid_later_busy", {31'd0, bus.busy}, 32'd0);
      check_hl("rst_mid_later", 32'd0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
